// File: rtl/barrel_shift_pkg.sv
// Shared op encodings and layer-grouping helpers for the pipelined barrel shifter.
package barrel_shift_pkg;

    // op = {rotate, right, arithmetic}
    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b110;

    function automatic int layers_per_stage(input int w, input int stages);
        int n;
        n = $clog2(w);
        return (n + stages - 1) / stages;
    endfunction

    // Number of log-shifter layers in group grp; trailing groups may hold none.
    function automatic int group_layers(input int w, input int stages, input int grp);
        int lps;
        int rem;
        lps = layers_per_stage(w, stages);
        rem = $clog2(w) - grp * lps;
        if (rem < 0) begin
            return 0;
        end
        if (rem > lps) begin
            return lps;
        end
        return rem;
    endfunction

endpackage

// File: rtl/shift_layer_group.sv
// A run of left-shift/rotate mux layers followed by one enable-gated pipeline register bank.
module shift_layer_group #(
    parameter int W           = 32,
    parameter int FIRST_LAYER = 0,
    parameter int N_LAYERS    = 1,
    localparam int SHAMT_W    = $clog2(W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               d_valid,
    input  logic [W-1:0]       d_data,
    input  logic [SHAMT_W-1:0] d_shamt,
    input  logic [2:0]         d_op,
    input  logic               d_fill,
    input  logic               d_carry,
    output logic               q_valid,
    output logic [W-1:0]       q_data,
    output logic [SHAMT_W-1:0] q_shamt,
    output logic [2:0]         q_op,
    output logic               q_fill,
    output logic               q_carry
);

    logic [W-1:0] chain [0:N_LAYERS];
    logic         unused_shamt;

    assign chain[0]     = d_data;
    // Every group sees the full shift amount but consumes only its own bits.
    assign unused_shamt = ^d_shamt;

    genvar gi;
    generate
        for (gi = 0; gi < N_LAYERS; gi++) begin : g_layer
            localparam int AMT = 1 << (FIRST_LAYER + gi);
            logic [W-1:0] shifted;
            assign shifted = d_op[2] ? {chain[gi][W-1-AMT:0], chain[gi][W-1 -: AMT]}
                                     : {chain[gi][W-1-AMT:0], {AMT{d_fill}}};
            assign chain[gi+1] = d_shamt[FIRST_LAYER + gi] ? shifted : chain[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_shamt <= '0;
            q_op    <= '0;
            q_fill  <= 1'b0;
            q_carry <= 1'b0;
        end else if (en) begin
            q_valid <= d_valid;
            q_data  <= chain[N_LAYERS];
            q_shamt <= d_shamt;
            q_op    <= d_op;
            q_fill  <= d_fill;
            q_carry <= d_carry;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shift.sv
// Pipelined shift/rotate unit: right ops are bit-reversed around a left log-shifter split into STAGES groups.
module pipelined_barrel_shift
    import barrel_shift_pkg::*;
#(
    parameter int W        = 32,
    parameter int STAGES   = 2,
    localparam int SHAMT_W = $clog2(W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [2:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       data_out,
    output logic               carry_out
);

    localparam int LPS = layers_per_stage(W, STAGES);

    // Index 0 is the combinational stage-0 front end; index s is the register after group s-1.
    logic               st_valid [0:STAGES];
    logic [W-1:0]       st_data  [0:STAGES];
    logic [SHAMT_W-1:0] st_shamt [0:STAGES];
    logic [2:0]         st_op    [0:STAGES];
    logic               st_fill  [0:STAGES];
    logic               st_carry [0:STAGES];

    logic [W-1:0]       in_rev;
    logic [W-1:0]       out_rev;
    logic [SHAMT_W-1:0] idx_left;
    logic [SHAMT_W-1:0] idx_right;
    logic               carry_first;
    logic               advance;
    logic               unused_tail;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_rev
            assign in_rev[gi]  = data_in[W-1-gi];
            assign out_rev[gi] = st_data[STAGES][W-1-gi];
        end
    endgenerate

    // Bit shifted out last: left ops lose data_in[W-shamt], right ops lose data_in[shamt-1].
    always_comb begin
        idx_left    = -shamt;
        idx_right   = shamt - SHAMT_W'(1);
        carry_first = 1'b0;
        if (shamt != '0) begin
            carry_first = op[1] ? data_in[idx_right] : data_in[idx_left];
        end
    end

    assign st_valid[0] = in_valid;
    assign st_data[0]  = op[1] ? in_rev : data_in;
    assign st_shamt[0] = shamt;
    assign st_op[0]    = op;
    assign st_fill[0]  = (op == OP_SRA) & data_in[W-1];
    assign st_carry[0] = carry_first;

    assign out_valid = st_valid[STAGES];
    assign advance   = !out_valid | out_ready;
    assign in_ready  = advance;

    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            shift_layer_group #(
                .W           (W),
                .FIRST_LAYER (gi * LPS),
                .N_LAYERS    (group_layers(W, STAGES, gi))
            ) u_group (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (advance),
                .d_valid (st_valid[gi]),
                .d_data  (st_data[gi]),
                .d_shamt (st_shamt[gi]),
                .d_op    (st_op[gi]),
                .d_fill  (st_fill[gi]),
                .d_carry (st_carry[gi]),
                .q_valid (st_valid[gi+1]),
                .q_data  (st_data[gi+1]),
                .q_shamt (st_shamt[gi+1]),
                .q_op    (st_op[gi+1]),
                .q_fill  (st_fill[gi+1]),
                .q_carry (st_carry[gi+1])
            );
        end
    endgenerate

    assign data_out  = st_op[STAGES][1] ? out_rev : st_data[STAGES];
    assign carry_out = st_carry[STAGES];

    assign unused_tail = ^{st_shamt[STAGES], st_fill[STAGES], st_op[STAGES][2], st_op[STAGES][0]};

endmodule

// File: tb/tb_pipelined_barrel_shift.sv
// Directed and swept checks of the pipelined barrel shifter at W=32.
module tb_pipelined_barrel_shift;
    import barrel_shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        carry_out;

    logic        sw_ready [1:5];
    logic        sw_valid [1:5];
    logic [31:0] sw_data  [1:5];
    logic        sw_carry [1:5];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  sh;
        logic [2:0]  op;
        logic [31:0] exp;
        logic        c;
    } vec_t;

    always #5 clk = ~clk;

    pipelined_barrel_shift #(.W(32), .STAGES(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shamt     (shamt),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .carry_out (carry_out)
    );

    genvar gi;
    generate
        for (gi = 1; gi <= 5; gi++) begin : g_sweep
            pipelined_barrel_shift #(.W(32), .STAGES(gi)) u_sw (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (sw_ready[gi]),
                .data_in   (data_in),
                .shamt     (shamt),
                .op        (op),
                .out_valid (sw_valid[gi]),
                .out_ready (out_ready),
                .data_out  (sw_data[gi]),
                .carry_out (sw_carry[gi])
            );
        end
    endgenerate

    // Behavioural reference: {carry, result}
    function automatic logic [32:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                              input logic [2:0] o);
        logic signed [31:0] sd;
        logic [31:0] res;
        logic        c;
        int          n;
        n  = int'(sh);
        sd = d;
        if (n == 0) begin
            res = d;
            c   = 1'b0;
        end else if (o[2] && !o[1]) begin
            res = (d << n) | (d >> (32 - n));
            c   = d[32 - n];
        end else if (o[2] && o[1]) begin
            res = (d >> n) | (d << (32 - n));
            c   = d[n - 1];
        end else if (!o[1]) begin
            res = d << n;
            c   = d[32 - n];
        end else if (o[0]) begin
            res = sd >>> n;
            c   = d[n - 1];
        end else begin
            res = d >> n;
            c   = d[n - 1];
        end
        return {c, res};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = 32'hDEAD_BEEF;
        shamt     = 5'd3;
        op        = OP_SLL;
        out_ready = 1'b1;
        step();
        step();
        checks += 4;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        if (data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00000000", data_out);
        end
        if (carry_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_carry: got %b expected 0", carry_out);
        end
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_shifts();
        vec_t v [10];
        v[0] = '{32'h8000_0001, 5'd4,  OP_SLL, 32'h0000_0010, 1'b0};
        v[1] = '{32'hF000_0000, 5'd4,  OP_SRA, 32'hFF00_0000, 1'b0};
        v[2] = '{32'hF000_0000, 5'd4,  OP_SRL, 32'h0F00_0000, 1'b0};
        v[3] = '{32'h0000_0001, 5'd1,  OP_ROR, 32'h8000_0000, 1'b1};
        v[4] = '{32'h8000_0000, 5'd31, OP_ROL, 32'h4000_0000, 1'b0};
        v[5] = '{32'h8000_0000, 5'd0,  OP_SRA, 32'h8000_0000, 1'b0};
        v[6] = '{32'h0000_0003, 5'd31, OP_SLL, 32'h8000_0000, 1'b1};
        v[7] = '{32'h8000_0000, 5'd31, OP_SRA, 32'hFFFF_FFFF, 1'b0};
        v[8] = '{32'h1234_5678, 5'd4,  OP_ROL, 32'h2345_6781, 1'b1};
        v[9] = '{32'hA500_00FF, 5'd8,  3'b101, 32'h0000_FFA5, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in  = v[i].d;
            shamt    = v[i].sh;
            op       = v[i].op;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL shift%0d_early_valid: got %b expected 0", i, out_valid);
            end
            step();
            checks += 3;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL shift%0d_valid: got %b expected 1", i, out_valid);
            end
            if (data_out !== v[i].exp) begin
                errors++;
                $display("FAIL shift%0d_data: got %h expected %h", i, data_out, v[i].exp);
            end
            if (carry_out !== v[i].c) begin
                errors++;
                $display("FAIL shift%0d_carry: got %b expected %b", i, carry_out, v[i].c);
            end
            $display("shift%0d d=%h sh=%0d op=%b -> %h c=%b", i, v[i].d, v[i].sh, v[i].op,
                     data_out, carry_out);
        end
        step();
    endtask

    task automatic test_back_to_back();
        vec_t bb [4];
        int   tx;
        int   rx;
        int   stall_left;
        bit   stall_done;
        logic [31:0] held_d;
        logic        held_c;
        bb[0] = '{32'h0000_00F8, 5'd4,  OP_SRL, 32'h0000_000F, 1'b1};
        bb[1] = '{32'h0000_00F0, 5'd8,  OP_SLL, 32'h0000_F000, 1'b0};
        bb[2] = '{32'h8765_4321, 5'd16, OP_ROR, 32'h4321_8765, 1'b0};
        bb[3] = '{32'h8000_0000, 5'd1,  OP_SRA, 32'hC000_0000, 1'b0};
        tx = 0;
        rx = 0;
        stall_left = 0;
        stall_done = 1'b0;
        held_d = '0;
        held_c = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (tx < 4) begin
                in_valid = 1'b1;
                data_in  = bb[tx].d;
                shamt    = bb[tx].sh;
                op       = bb[tx].op;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid && !stall_done) begin
                stall_left = 3;
                stall_done = 1'b1;
                held_d = data_out;
                held_c = carry_out;
            end
            out_ready = (stall_left == 0);
            #1;
            if (!out_ready) begin
                checks += 3;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready: got %b expected 0", in_ready);
                end
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_valid: got %b expected 1", out_valid);
                end
                if (data_out !== held_d || carry_out !== held_c) begin
                    errors++;
                    $display("FAIL stall_hold: got %h/%b expected %h/%b", data_out, carry_out,
                             held_d, held_c);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (rx >= 4) begin
                    errors++;
                    $display("FAIL b2b_extra: got result %h expected none", data_out);
                end else begin
                    if (data_out !== bb[rx].exp || carry_out !== bb[rx].c) begin
                        errors++;
                        $display("FAIL b2b%0d: got %h/%b expected %h/%b", rx, data_out, carry_out,
                                 bb[rx].exp, bb[rx].c);
                    end
                    $display("b2b%0d -> %h c=%b", rx, data_out, carry_out);
                end
                rx++;
            end
            if (in_valid && in_ready) begin
                tx++;
            end
            if (stall_left > 0) begin
                stall_left--;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rx != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 4", rx);
        end
    endtask

    task automatic test_midflight_reset();
        out_ready = 1'b1;
        data_in   = 32'h0000_0001;
        shamt     = 5'd2;
        op        = OP_SLL;
        in_valid  = 1'b1;
        step();
        data_in = 32'h0000_0100;
        op      = OP_SRL;
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_valid: got %b expected 0", out_valid);
        end
        if (data_out !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_data: got %h expected 00000000", data_out);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_result%0d: got valid %b expected 0", i, out_valid);
            end
        end
        $display("midflight reset: pipeline flushed");
    endtask

    task automatic test_stage_sweep();
        logic [32:0] exp;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        for (int v = 0; v < 12; v++) begin
            data_in  = $urandom;
            shamt    = (v == 0) ? 5'd0 : (v == 1) ? 5'd31 : 5'($urandom_range(0, 31));
            op       = 3'($urandom_range(0, 7));
            exp      = ref_shift(data_in, shamt, op);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                for (int k = 1; k <= 5; k++) begin
                    checks++;
                    if (sw_valid[k] !== (c == k)) begin
                        errors++;
                        $display("FAIL sweep_s%0d_valid_cyc%0d: got %b expected %b", k, c,
                                 sw_valid[k], (c == k));
                    end
                    if (c == k) begin
                        checks++;
                        if (sw_data[k] !== exp[31:0] || sw_carry[k] !== exp[32]
                                || sw_ready[k] !== 1'b1) begin
                            errors++;
                            $display("FAIL sweep_s%0d_result: got %h/%b expected %h/%b", k,
                                     sw_data[k], sw_carry[k], exp[31:0], exp[32]);
                        end
                    end
                end
                if (c < 5) begin
                    step();
                end
            end
            $display("sweep%0d d=%h sh=%0d op=%b -> %h c=%b", v, data_in, shamt, op,
                     exp[31:0], exp[32]);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_shifts();
        test_back_to_back();
        test_midflight_reset();
        test_stage_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
